// File: rtl/operand_collect.sv
// operand_collect: operand-collect stage between issue and execute.
//
// Each issue port owns a one-entry holding slot. On capture, both source
// operands are resolved from the ARF, the writeback bypass network, or the
// PRF. An operand that cannot be resolved keeps its physical tag, and the slot
// keeps snooping the bypass network until the value arrives. The instruction
// is released only when both operands are ready.
//
// Ports (all per-port buses are flat, port i in slice [i*W +: W]):
//   clk, reset            clock, asynchronous active-high reset
//   flush                 synchronous flush, clears every slot
//   in_valid / in_ready   issue handshake per port
//   in_src*, in_psrc*     architectural sources / physical tags
//   in_fwd*               1 = operand comes from PRF/bypass, 0 = from ARF
//   in_payload            opaque payload, passed through
//   arf_raddr*/arf_rdata* ARF read ports (same-cycle data)
//   prf_raddr*/prf_rdata*/prf_rvalid*  PRF read ports (same-cycle data)
//   byp_valid/tag/data    writeback broadcast channels
//   out_valid / out_ready execute handshake per port
//   out_op*, out_payload  registered operands and payload
module operand_collect #(
    parameter int NUM_PORTS  = 8,
    parameter int XLEN       = 64,
    parameter int AREG_W     = 5,
    parameter int PREG_W     = 6,
    parameter int NUM_BYPASS = 4,
    parameter int PAYLOAD_W  = 96
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS*AREG_W-1:0]     in_src1,
    input  logic [NUM_PORTS*AREG_W-1:0]     in_src2,
    input  logic [NUM_PORTS*PREG_W-1:0]     in_psrc1,
    input  logic [NUM_PORTS*PREG_W-1:0]     in_psrc2,
    input  logic [NUM_PORTS-1:0]            in_fwd1,
    input  logic [NUM_PORTS-1:0]            in_fwd2,
    input  logic [NUM_PORTS*PAYLOAD_W-1:0]  in_payload,
    output logic [NUM_PORTS*AREG_W-1:0]     arf_raddr1,
    output logic [NUM_PORTS*AREG_W-1:0]     arf_raddr2,
    input  logic [NUM_PORTS*XLEN-1:0]       arf_rdata1,
    input  logic [NUM_PORTS*XLEN-1:0]       arf_rdata2,
    output logic [NUM_PORTS*PREG_W-1:0]     prf_raddr1,
    output logic [NUM_PORTS*PREG_W-1:0]     prf_raddr2,
    input  logic [NUM_PORTS*XLEN-1:0]       prf_rdata1,
    input  logic [NUM_PORTS*XLEN-1:0]       prf_rdata2,
    input  logic [NUM_PORTS-1:0]            prf_rvalid1,
    input  logic [NUM_PORTS-1:0]            prf_rvalid2,
    input  logic [NUM_BYPASS-1:0]           byp_valid,
    input  logic [NUM_BYPASS*PREG_W-1:0]    byp_tag,
    input  logic [NUM_BYPASS*XLEN-1:0]      byp_data,
    output logic [NUM_PORTS-1:0]            out_valid,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic [NUM_PORTS*XLEN-1:0]       out_op1,
    output logic [NUM_PORTS*XLEN-1:0]       out_op2,
    output logic [NUM_PORTS*PAYLOAD_W-1:0]  out_payload
);

    // Bypass lookup: returns {hit, data}. Channels are scanned from the top
    // down so the lowest-index matching channel is the one left standing.
    function automatic logic [XLEN:0] byp_lookup(
        input logic [PREG_W-1:0]            tag,
        input logic [NUM_BYPASS-1:0]        v,
        input logic [NUM_BYPASS*PREG_W-1:0] t,
        input logic [NUM_BYPASS*XLEN-1:0]   d
    );
        logic [XLEN:0] r;
        r = '0;
        for (int c = NUM_BYPASS - 1; c >= 0; c--) begin
            if (v[c] && (t[c*PREG_W +: PREG_W] == tag)) begin
                r = {1'b1, d[c*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    // Capture-time resolve: returns {ready, value}.
    function automatic logic [XLEN:0] resolve(
        input logic [AREG_W-1:0] src,
        input logic              fwd,
        input logic [XLEN-1:0]   arf,
        input logic [XLEN-1:0]   prf,
        input logic              prf_v,
        input logic [XLEN:0]     byp
    );
        logic [XLEN:0] r;
        if (!fwd) begin
            // x0 reads as zero whatever the ARF returns
            r = (src == '0) ? {1'b1, {XLEN{1'b0}}} : {1'b1, arf};
        end else if (byp[XLEN]) begin
            r = byp;
        end else if (prf_v) begin
            r = {1'b1, prf};
        end else begin
            r = '0;
        end
        return r;
    endfunction

    assign arf_raddr1 = in_src1;
    assign arf_raddr2 = in_src2;
    assign prf_raddr1 = in_psrc1;
    assign prf_raddr2 = in_psrc2;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
        logic                 held_q, rdy1_q, rdy2_q;
        logic [PREG_W-1:0]    tag1_q, tag2_q;
        logic [XLEN-1:0]      op1_q, op2_q;
        logic [PAYLOAD_W-1:0] payload_q;

        logic [XLEN:0] cap1, cap2, snp1, snp2;
        logic          valid, fire, accept, capture;

        always_comb begin
            cap1 = resolve(in_src1[i*AREG_W +: AREG_W], in_fwd1[i],
                           arf_rdata1[i*XLEN +: XLEN], prf_rdata1[i*XLEN +: XLEN],
                           prf_rvalid1[i],
                           byp_lookup(in_psrc1[i*PREG_W +: PREG_W], byp_valid, byp_tag, byp_data));
            cap2 = resolve(in_src2[i*AREG_W +: AREG_W], in_fwd2[i],
                           arf_rdata2[i*XLEN +: XLEN], prf_rdata2[i*XLEN +: XLEN],
                           prf_rvalid2[i],
                           byp_lookup(in_psrc2[i*PREG_W +: PREG_W], byp_valid, byp_tag, byp_data));
            snp1 = byp_lookup(tag1_q, byp_valid, byp_tag, byp_data);
            snp2 = byp_lookup(tag2_q, byp_valid, byp_tag, byp_data);
        end

        assign valid   = held_q & rdy1_q & rdy2_q;
        assign fire    = valid & out_ready[i];
        // Accepting while firing keeps back-to-back issue at full rate.
        assign accept  = ~held_q | fire;
        assign capture = in_valid[i] & accept & ~flush;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                held_q    <= 1'b0;
                rdy1_q    <= 1'b0;
                rdy2_q    <= 1'b0;
                tag1_q    <= '0;
                tag2_q    <= '0;
                op1_q     <= '0;
                op2_q     <= '0;
                payload_q <= '0;
            end else if (flush) begin
                held_q <= 1'b0;
                rdy1_q <= 1'b0;
                rdy2_q <= 1'b0;
            end else if (capture) begin
                held_q    <= 1'b1;
                rdy1_q    <= cap1[XLEN];
                rdy2_q    <= cap2[XLEN];
                tag1_q    <= in_psrc1[i*PREG_W +: PREG_W];
                tag2_q    <= in_psrc2[i*PREG_W +: PREG_W];
                op1_q     <= cap1[XLEN-1:0];
                op2_q     <= cap2[XLEN-1:0];
                payload_q <= in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end else begin
                if (fire) begin
                    held_q <= 1'b0;
                end
                // Ready operands are never overwritten by a later broadcast.
                if (held_q && !rdy1_q && snp1[XLEN]) begin
                    rdy1_q <= 1'b1;
                    op1_q  <= snp1[XLEN-1:0];
                end
                if (held_q && !rdy2_q && snp2[XLEN]) begin
                    rdy2_q <= 1'b1;
                    op2_q  <= snp2[XLEN-1:0];
                end
            end
        end

        assign in_ready[i]                          = accept;
        assign out_valid[i]                         = valid;
        assign out_op1[i*XLEN +: XLEN]              = op1_q;
        assign out_op2[i*XLEN +: XLEN]              = op2_q;
        assign out_payload[i*PAYLOAD_W +: PAYLOAD_W] = payload_q;
    end

endmodule

// File: tb/tb_operand_collect.sv
// Directed bench for operand_collect: ARF path, pending PRF operand resolved by
// bypass snoop, capture-time bypass priority, PRF path, backpressure, flush and
// asynchronous reset.
module tb_operand_collect;
    localparam int NP = 8;
    localparam int XL = 64;
    localparam int AW = 5;
    localparam int PW = 6;
    localparam int NB = 4;
    localparam int PLW = 96;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic [NP-1:0]     in_valid = '0, in_ready;
    logic [NP*AW-1:0]  in_src1 = '0, in_src2 = '0;
    logic [NP*PW-1:0]  in_psrc1 = '0, in_psrc2 = '0;
    logic [NP-1:0]     in_fwd1 = '0, in_fwd2 = '0;
    logic [NP*PLW-1:0] in_payload = '0;
    logic [NP*AW-1:0]  arf_raddr1, arf_raddr2;
    logic [NP*XL-1:0]  arf_rdata1, arf_rdata2;
    logic [NP*PW-1:0]  prf_raddr1, prf_raddr2;
    logic [NP*XL-1:0]  prf_rdata1, prf_rdata2;
    logic [NP-1:0]     prf_rvalid1, prf_rvalid2;
    logic [NB-1:0]     byp_valid = '0;
    logic [NB*PW-1:0]  byp_tag = '0;
    logic [NB*XL-1:0]  byp_data = '0;
    logic [NP-1:0]     out_valid, out_ready = '0;
    logic [NP*XL-1:0]  out_op1, out_op2;
    logic [NP*PLW-1:0] out_payload;

    logic [XL-1:0] arf_mem [32];
    logic [XL-1:0] prf_mem [64];
    logic          prf_wr  [64];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_collect dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2),
        .in_psrc1(in_psrc1), .in_psrc2(in_psrc2),
        .in_fwd1(in_fwd1), .in_fwd2(in_fwd2),
        .in_payload(in_payload),
        .arf_raddr1(arf_raddr1), .arf_raddr2(arf_raddr2),
        .arf_rdata1(arf_rdata1), .arf_rdata2(arf_rdata2),
        .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
        .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
        .prf_rvalid1(prf_rvalid1), .prf_rvalid2(prf_rvalid2),
        .byp_valid(byp_valid), .byp_tag(byp_tag), .byp_data(byp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_payload(out_payload)
    );

    // Register-file models answer whatever address the DUT presents.
    always_comb begin
        arf_rdata1 = '0; arf_rdata2 = '0;
        prf_rdata1 = '0; prf_rdata2 = '0;
        prf_rvalid1 = '0; prf_rvalid2 = '0;
        for (int i = 0; i < NP; i++) begin
            arf_rdata1[i*XL +: XL] = arf_mem[arf_raddr1[i*AW +: AW]];
            arf_rdata2[i*XL +: XL] = arf_mem[arf_raddr2[i*AW +: AW]];
            prf_rdata1[i*XL +: XL] = prf_mem[prf_raddr1[i*PW +: PW]];
            prf_rdata2[i*XL +: XL] = prf_mem[prf_raddr2[i*PW +: PW]];
            prf_rvalid1[i] = prf_wr[prf_raddr1[i*PW +: PW]];
            prf_rvalid2[i] = prf_wr[prf_raddr2[i*PW +: PW]];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                         input logic [PW-1:0] ps1, input logic [PW-1:0] ps2,
                         input logic f1, input logic f2, input logic [PLW-1:0] pl);
        in_src1[p*AW +: AW]     = s1;
        in_src2[p*AW +: AW]     = s2;
        in_psrc1[p*PW +: PW]    = ps1;
        in_psrc2[p*PW +: PW]    = ps2;
        in_fwd1[p]              = f1;
        in_fwd2[p]              = f2;
        in_payload[p*PLW +: PLW] = pl;
        in_valid[p]             = 1'b1;
    endtask

    task automatic bcast(input int c, input logic [PW-1:0] t, input logic [XL-1:0] d);
        byp_valid[c]        = 1'b1;
        byp_tag[c*PW +: PW] = t;
        byp_data[c*XL +: XL] = d;
    endtask

    task automatic idle();
        in_valid  = '0;
        byp_valid = '0;
        flush     = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) arf_mem[r] = 64'h1000 + 64'(r);
        arf_mem[0] = 64'hDEAD;
        arf_mem[3] = 64'h11;
        arf_mem[7] = 64'h77;
        for (int r = 0; r < 64; r++) begin
            prf_mem[r] = 64'h2000 + 64'(r);
            prf_wr[r]  = 1'b0;
        end
        prf_mem[5]  = 64'h55;
        prf_wr[5]   = 1'b1;
        prf_mem[12] = 64'h1234;
        prf_wr[12]  = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_in_ready", 128'(in_ready), 128'hFF);
        check("rst_op1_p0", 128'(out_op1[0 +: XL]), 128'h0);
        step();
        reset = 1'b0;
        out_ready = '1;

        // ARF path; src2=0 must read zero even though ARF[0] is nonzero
        issue(0, 5'd3, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 96'hA5A5);
        #1;
        check("arf_in_ready", 128'(in_ready[0]), 128'h1);
        step(); idle();
        check("arf_valid", 128'(out_valid[0]), 128'h1);
        check("arf_op1", 128'(out_op1[0 +: XL]), 128'h11);
        check("arf_op2_zero", 128'(out_op2[0 +: XL]), 128'h0);
        check("arf_payload", 128'(out_payload[0 +: PLW]), 128'hA5A5);
        step();
        check("arf_empty", 128'(out_valid[0]), 128'h0);
        check("arf_ready_again", 128'(in_ready[0]), 128'h1);

        // PRF pending then bypass on channel 1
        issue(2, 5'd0, 5'd0, 6'd9, 6'd0, 1'b1, 1'b0, 96'h22);
        step(); idle();
        check("pend_wait0", 128'(out_valid[2]), 128'h0);
        bcast(0, 6'd33, 64'hBAD); // unrelated tag
        step();
        check("pend_wait1", 128'(out_valid[2]), 128'h0);
        byp_valid = '0;
        bcast(1, 6'd9, 64'hABCD);
        #1;
        check("pend_wait_bcast", 128'(out_valid[2]), 128'h0);
        step(); idle();
        check("pend_valid", 128'(out_valid[2]), 128'h1);
        check("pend_op1", 128'(out_op1[2*XL +: XL]), 128'hABCD);
        check("pend_op2", 128'(out_op2[2*XL +: XL]), 128'h0);
        step();
        check("pend_empty", 128'(out_valid[2]), 128'h0);

        // Capture-cycle bypass beats PRF; ch0 beats ch3
        issue(1, 5'd0, 5'd0, 6'd0, 6'd5, 1'b0, 1'b1, 96'h11);
        bcast(3, 6'd5, 64'h2);
        bcast(0, 6'd5, 64'h1);
        step(); idle();
        check("capbyp_valid", 128'(out_valid[1]), 128'h1);
        check("capbyp_op2", 128'(out_op2[XL +: XL]), 128'h1);
        step();

        // PRF already written; ARF on the other operand
        issue(3, 5'd0, 5'd7, 6'd12, 6'd0, 1'b1, 1'b0, 96'h33);
        step(); idle();
        check("prf_valid", 128'(out_valid[3]), 128'h1);
        check("prf_op1", 128'(out_op1[3*XL +: XL]), 128'h1234);
        check("prf_op2", 128'(out_op2[3*XL +: XL]), 128'h77);
        step();

        // Backpressure on port 4; a blocked request must not be captured
        out_ready[4] = 1'b0;
        issue(4, 5'd3, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 96'hF1);
        step();
        issue(4, 5'd7, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 96'hBAD0);
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready", 128'(in_ready[4]), 128'h0);
            check("bp_valid", 128'(out_valid[4]), 128'h1);
            check("bp_op1", 128'(out_op1[4*XL +: XL]), 128'h11);
            check("bp_payload", 128'(out_payload[4*PLW +: PLW]), 128'hF1);
            step();
        end
        out_ready[4] = 1'b1;
        issue(4, 5'd7, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 96'hF2);
        #1;
        check("bp_release_ready", 128'(in_ready[4]), 128'h1);
        step(); idle();
        check("bp_new_valid", 128'(out_valid[4]), 128'h1);
        check("bp_new_op1", 128'(out_op1[4*XL +: XL]), 128'h77);
        check("bp_new_payload", 128'(out_payload[4*PLW +: PLW]), 128'hF2);
        step();
        check("bp_empty", 128'(out_valid[4]), 128'h0);

        // Flush: port5 pending on tag 20, port6 stalled and ready
        out_ready[6] = 1'b0;
        issue(5, 5'd0, 5'd0, 6'd20, 6'd0, 1'b1, 1'b0, 96'h55);
        issue(6, 5'd3, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 96'h66);
        step(); idle();
        check("fl_pre_valid", 128'(out_valid), 128'h40);
        check("fl_pre_ready", 128'(in_ready), 128'h9F);
        for (int p = 0; p < NP; p++) issue(p, 5'd3, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 96'h99);
        flush = 1'b1;
        step(); idle();
        check("fl_valid", 128'(out_valid), 128'h0);
        check("fl_ready", 128'(in_ready), 128'hFF);
        bcast(2, 6'd20, 64'h2020);
        step(); idle();
        check("fl_byp_valid", 128'(out_valid), 128'h0);
        step();
        check("fl_byp_valid2", 128'(out_valid), 128'h0);
        out_ready = '1;

        // Asynchronous reset with four slots held
        out_ready[3:0] = 4'h0;
        for (int p = 0; p < 4; p++) issue(p, 5'd3, 5'd7, 6'd0, 6'd0, 1'b0, 1'b0, 96'h44);
        step(); idle();
        check("ar_pre_valid", 128'(out_valid), 128'h0F);
        check("ar_pre_ready", 128'(in_ready), 128'hF0);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 128'(out_valid), 128'h0);
        check("ar_ready", 128'(in_ready), 128'hFF);
        check("ar_op2_p1", 128'(out_op2[XL +: XL]), 128'h0);
        step();
        reset = 1'b0;
        out_ready = '1;
        step();
        check("ar_post_valid", 128'(out_valid), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
